// File: rtl/count_display_pkg.sv
// rtl/count_display_pkg.sv - shared FSM states, segment codes and digit decode
// for count_display_driver.
package count_display_pkg;

  localparam int NUM_W_DEF      = 4;
  localparam int NUM_DIGITS_DEF = 2;
  localparam int SCAN_DIV_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter.
module bin2bcd_seq
  import count_display_pkg::*;
#(
  parameter int NUM_W      = NUM_W_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic                    CLK,
  input  logic                    CLEAR_BAR,
  input  logic                    start,
  input  logic [NUM_W-1:0]        bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_W + 1);

  conv_state_t      state, state_nx;
  logic [NUM_W-1:0] snap;
  logic [BW-1:0]    sr, sr_adj;
  logic [CW-1:0]    cnt;

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr[4*i +: 4] >= 4'd5) sr_adj[4*i +: 4] = sr[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(NUM_W - 1)) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLEAR_BAR) begin
    if (!CLEAR_BAR) begin
      state <= IDLE;
      snap  <= '0;
      sr    <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          snap <= bin;
          sr   <= '0;
          cnt  <= '0;
        end
        SHIFT: begin
          sr   <= {sr_adj[BW-2:0], snap[NUM_W-1]};
          snap <= snap << 1;
          cnt  <= cnt + 1'b1;
        end
        // Publishing only here keeps a half-converted value off the output
        DONE: bcd <= sr;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// rtl/count_display_driver.sv - count to BCD conversion and multiplexed 7-seg drive;
// LEADING_ZERO_BLANK_EN blanks leading zero digits above digit0.
module count_display_driver
  import count_display_pkg::*;
#(
  parameter int NUM_W      = NUM_W_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
  input  logic                    CLK,
  input  logic                    CLEAR_BAR,
  input  logic [NUM_W-1:0]        NUM,
  output logic [4*NUM_DIGITS-1:0] BCD,
  output logic                    UPDATE,
  output logic [6:0]              SEG,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NUM_W-1:0] num_q, last, pend;
  logic             busy, start, done;
  logic [PW-1:0]    pre;
  logic [IW-1:0]    idx;
  logic [3:0]       cur;
  logic [6:0]       seg_nx;
`ifdef LEADING_ZERO_BLANK_EN
  logic             lead;
`endif

  // busy mirrors the engine leaving IDLE, so start is only seen when it can accept
  assign start = !busy && (num_q != last);

  bin2bcd_seq #(
    .NUM_W      (NUM_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .CLK       (CLK),
    .CLEAR_BAR (CLEAR_BAR),
    .start     (start),
    .bin       (num_q),
    .bcd       (BCD),
    .done      (done)
  );

  always_ff @(posedge CLK or negedge CLEAR_BAR) begin
    if (!CLEAR_BAR) begin
      num_q  <= '0;
      last   <= '0;
      pend   <= '0;
      busy   <= 1'b0;
      UPDATE <= 1'b0;
    end else begin
      num_q  <= NUM;
      UPDATE <= done;
      if (start) begin
        busy <= 1'b1;
        pend <= num_q;
      end else if (done) begin
        busy <= 1'b0;
        last <= pend;
      end
    end
  end

  always_comb begin
    cur    = BCD[4*idx +: 4];
    seg_nx = digit_to_seg(cur);
`ifdef LEADING_ZERO_BLANK_EN
    lead = (idx != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && BCD[4*j +: 4] != 4'd0) lead = 1'b0;
    end
    if (lead) seg_nx = SEG_BLANK;
`endif
  end

  always_ff @(posedge CLK or negedge CLEAR_BAR) begin
    if (!CLEAR_BAR) begin
      pre <= '0;
      idx <= '0;
      AN  <= ~NUM_DIGITS'(1);
      SEG <= SEG_0;
    end else begin
      if (pre == PW'(SCAN_DIV - 1)) begin
        pre <= '0;
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      AN  <= ~(NUM_DIGITS'(1) << idx);
      SEG <= seg_nx;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// tb/tb_count_display_driver.sv - self-checking bench for count_display_driver.
module tb_count_display_driver;

  localparam int SCAN = 4;
  localparam int ND   = 2;
  localparam logic [6:0] SEGTAB [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic       CLK = 1'b0;
  logic       CLEAR_BAR = 1'b1;
  logic [3:0] NUM = 4'd0;
  logic [7:0] BCD;
  logic       UPDATE;
  logic [6:0] SEG;
  logic [1:0] AN;

  count_display_driver dut (
    .CLK       (CLK),
    .CLEAR_BAR (CLEAR_BAR),
    .NUM       (NUM),
    .BCD       (BCD),
    .UPDATE    (UPDATE),
    .SEG       (SEG),
    .AN        (AN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int         n, pub_edge, pub_val, last_m, prev_numq;
  bit         pending;
  logic [7:0] exp_bcd;
  logic       exp_upd;
  logic [6:0] exp_seg;
  logic [1:0] exp_an;
  logic [7:0] rec[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [6:0] seg_for(input int d, input logic [7:0] b);
    int v;
    v = (d == 0) ? int'(b[3:0]) : int'(b[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && v == 0) return 7'b1111111;
`endif
    return (v > 9) ? 7'b1111111 : SEGTAB[v];
  endfunction

  task automatic model_reset();
    n = 0; pending = 0; last_m = 0; prev_numq = 0; pub_edge = 0; pub_val = 0;
    exp_bcd = 8'h00; exp_upd = 1'b0; exp_an = 2'b10; exp_seg = 7'b1000000;
  endtask

  // A new count is accepted only when no conversion is in flight; it is
  // published six edges after it was sampled (five after acceptance).
  task automatic model_edge();
    bit idle;
    int d;
    n++;
    d       = ((n - 1) / SCAN) % ND;
    exp_an  = ~(2'b01 << d);
    exp_seg = seg_for(d, exp_bcd);
    idle    = !pending;
    exp_upd = 1'b0;
    if (pending && pub_edge == n) begin
      exp_bcd = to_bcd(pub_val);
      exp_upd = 1'b1;
      last_m  = pub_val;
      pending = 0;
    end
    if (idle && prev_numq != last_m) begin
      pending  = 1;
      pub_edge = n + 5;
      pub_val  = prev_numq;
    end
    prev_numq = int'(NUM);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("bcd", 32'(BCD), 32'(exp_bcd));
    chk("update", 32'(UPDATE), 32'(exp_upd));
    chk("an", 32'(AN), 32'(exp_an));
    chk("seg", 32'(SEG), 32'(exp_seg));
    if (UPDATE) rec.push_back(BCD);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    bit found;
    #1 CLEAR_BAR = 1'b0;
    #1;
    chk("rst_bcd", 32'(BCD), 32'h00);
    chk("rst_update", 32'(UPDATE), 32'h0);
    chk("rst_an", 32'(AN), 32'h2);
    chk("rst_seg", 32'(SEG), 32'(7'b1000000));
    @(negedge CLK);
    CLEAR_BAR = 1'b1;
    model_reset();
    ticks(3);

    NUM = 4'd9;
    rec.delete();
    ticks(10);
    chk("nine_bcd", 32'(BCD), 32'h09);
    chk("nine_updates", 32'(rec.size()), 32'd1);

    NUM = 4'd15;
    ticks(20);
    chk("fifteen_bcd", 32'(BCD), 32'h15);

    NUM = 4'd3;
    rec.delete();
    ticks(4);
    NUM = 4'd4;
    ticks(16);
    chk("midshift_count", 32'(rec.size()), 32'd2);
    if (rec.size() == 2) begin
      chk("midshift_first", 32'(rec[0]), 32'h03);
      chk("midshift_second", 32'(rec[1]), 32'h04);
    end

    NUM = 4'd12;
    ticks(3);
    #2 CLEAR_BAR = 1'b0;
    #1;
    chk("abort_bcd", 32'(BCD), 32'h00);
    chk("abort_update", 32'(UPDATE), 32'h0);
    chk("abort_an", 32'(AN), 32'h2);
    chk("abort_seg", 32'(SEG), 32'(7'b1000000));
    @(negedge CLK);
    CLEAR_BAR = 1'b1;
    model_reset();
    rec.delete();
    ticks(5);
    chk("abort_no_early_update", 32'(rec.size()), 32'd0);
    ticks(3);
    chk("twelve_bcd", 32'(BCD), 32'h12);

    NUM = 4'd15;
    ticks(10);
    NUM = 4'd0;
    ticks(10);
    chk("wrap_bcd", 32'(BCD), 32'h00);

    NUM = 4'd7;
    ticks(10);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (AN == 2'b01) found = 1;
      else tick();
    end
    chk("digit1_found", 32'(found), 32'd1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("digit1_seg", 32'(SEG), 32'(7'b1111111));
`else
    chk("digit1_seg", 32'(SEG), 32'(7'b1000000));
`endif

    for (int r = 0; r < 40; r++) begin
      NUM = 4'($urandom_range(0, 15));
      ticks(int'($urandom_range(1, 12)));
    end
    ticks(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
